arch_maptable: RTL and testbench
================================

Name: arch_maptable

Overview:
- Architectural map table (AMT): holds the committed arch-reg -> phys-tag mapping.
- Written by the ROB at retirement; supplies the snapshot the speculative map table loads on rollback.
- Returns each superseded physical tag to the free list.
- Sits between the ROB retire stage, the speculative map table (consumes amt_o) and the free list (consumes amt_fl_o).

Parameters:
- C_RT_NUM, `RT_NUM (2): retire slots per cycle; slot 0 is oldest.
- C_MT_ENTRY, `MT_ENTRY (32): architectural registers.
- C_TAG_IDX_WIDTH, `TAG_IDX_WIDTH (6): physical tag width.
- C_ARCH_IDX_WIDTH, $clog2(C_MT_ENTRY) (5): arch index width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- rollback_i  in  1  ROB flush pulse.
- rob_amt_i  in  C_RT_NUM x ROB_AMT  per slot: wr_en, arch_reg[C_ARCH_IDX_WIDTH], phy_tag[C_TAG_IDX_WIDTH].
- amt_o  out  C_MT_ENTRY x AMT_ENTRY  per entry: amt_tag[C_TAG_IDX_WIDTH].
- amt_fl_o  out  C_RT_NUM x AMT_FL  per slot: valid, tag; freed tags to the free list.

Behaviour:
- Reset (async, rst_n_i low):
  - Entry i amt_tag = i.
  - All amt_fl_o valid = 0, tag = 0.
- Retire commit:
  - For each slot r with wr_en, at the next edge: entry[arch_reg].amt_tag <= phy_tag.
  - Slots are applied in order 0..C_RT_NUM-1; the youngest write to an entry wins.
- Freed tag, slot r:
  - Equals the mapping the arch_reg held immediately before slot r, including earlier same-cycle slots.
  - Example: slots 0 and 1 both retire x5, tags 40 then 41, old mapping 7 -> slot 0 frees 7, slot 1 frees 40, entry 5 ends at 41.
  - Registered: amt_fl_o[r] is valid exactly 1 cycle after the retire cycle.
  - valid = 0 for slots without wr_en.
- amt_o:
  - Combinational bypass of the next state: stored table with all same-cycle retirements applied.
  - The map table sampling amt_o on a rollback edge therefore sees retirements from that same cycle.
  - With no retirements, amt_o equals the stored table.
- rollback_i:
  - Does not alter AMT contents; retirements in the rollback cycle still commit and still free tags.
  - No internal state is cleared.
- Arch reg 0: treated like any other entry; the ROB never retires wr_en for x0.
- Reset mid-operation: pending amt_fl_o outputs are dropped; the table returns to identity.
- Same phy_tag retired twice without an intervening free is illegal; no checking is required.

Optional Feature:
- Macro ARCH_MT_STAT_EN.
- Defined:
  - Adds outputs retire_cnt_o[31:0], the total committed writes, incremented by the number of wr_en slots per cycle.
  - Adds rollback_cnt_o[15:0], incremented per rollback_i cycle.
  - Both counters wrap modulo 2^N and reset to 0.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Decomposition:
- Shared package sys_defs:
  - Structs ROB_AMT, AMT_ENTRY, AMT_FL.
  - Macros `RT_NUM, `MT_ENTRY, `TAG_IDX_WIDTH.
- Sub-module amt_retire_merge, combinational:
  - Inputs: stored table, rob_amt_i.
  - Outputs: next-state table and per-slot old tags, using the in-order chain.
- Top level holds the flops, the amt_fl_o register stage and the optional counters.

Test Plan:
- Reset -> amt_o[i].amt_tag == i for all i; amt_fl_o valid all 0; mid-run reset pulse also clears a pending amt_fl_o.
- Slot 0 retires x3 -> tag 33 -> amt_o[3] == 33 in the same cycle (bypass), stored next cycle; amt_fl_o[0] = {1, 3} one cycle later.
- Slots 0 and 1 retire x5 -> 40 and x5 -> 41 -> amt_o[5] == 41; amt_fl_o = {1, 5} and {1, 40}.
- Slot 0 x1 -> 50, slot 1 x2 -> 51 with rollback_i high -> amt_o shows 50 and 51 that cycle; contents persist after rollback; frees 1 and 2.
- Idle cycle, then slot 1 only wr_en x7 -> 60 -> amt_fl_o[0].valid == 0, amt_fl_o[1] = {1, 7}.
- With ARCH_MT_STAT_EN: 3 cycles of 2 retires plus 1 rollback -> retire_cnt_o == 6, rollback_cnt_o == 1.

Source files
------------

// File: rtl/sys_defs.sv
// -----------------------------------------------------------------------------
// sys_defs -- shared definitions for the architectural map table (AMT).
//
// Macros:
//   `RT_NUM        retire slots per cycle (slot 0 is oldest)
//   `MT_ENTRY      number of architectural registers
//   `TAG_IDX_WIDTH physical tag width
//
// Types:
//   ROB_AMT   one retire slot from the ROB: wr_en, arch_reg, phy_tag
//   AMT_ENTRY one committed mapping: amt_tag
//   AMT_FL    one freed tag toward the free list: valid, tag
//
// Optional feature macro used elsewhere: ARCH_MT_STAT_EN.
// -----------------------------------------------------------------------------
`ifndef RT_NUM
`define RT_NUM 2
`endif
`ifndef MT_ENTRY
`define MT_ENTRY 32
`endif
`ifndef TAG_IDX_WIDTH
`define TAG_IDX_WIDTH 6
`endif

package sys_defs;

    localparam int RT_NUM         = `RT_NUM;
    localparam int MT_ENTRY       = `MT_ENTRY;
    localparam int TAG_IDX_WIDTH  = `TAG_IDX_WIDTH;
    localparam int ARCH_IDX_WIDTH = $clog2(`MT_ENTRY);

    typedef struct packed {
        logic                      wr_en;
        logic [ARCH_IDX_WIDTH-1:0] arch_reg;
        logic [TAG_IDX_WIDTH-1:0]  phy_tag;
    } ROB_AMT;

    typedef struct packed {
        logic [TAG_IDX_WIDTH-1:0] amt_tag;
    } AMT_ENTRY;

    typedef struct packed {
        logic                     valid;
        logic [TAG_IDX_WIDTH-1:0] tag;
    } AMT_FL;

endpackage

// File: rtl/arch_maptable_retire_merge.sv
// -----------------------------------------------------------------------------
// amt_retire_merge -- combinational application of one cycle's retirements to
// the stored architectural map table.
//
// Ports:
//   table_i    stored table (one AMT_ENTRY per arch register)
//   rob_amt_i  retire slots, slot 0 oldest
//   table_o    table with every enabled slot applied in order 0..C_RT_NUM-1
//   old_tag_o  per slot: mapping the slot's arch_reg held just before that
//              slot, i.e. after all older same-cycle slots were applied
// -----------------------------------------------------------------------------
module amt_retire_merge
    import sys_defs::*;
#(
    parameter int C_RT_NUM        = `RT_NUM,
    parameter int C_MT_ENTRY      = `MT_ENTRY,
    parameter int C_TAG_IDX_WIDTH = `TAG_IDX_WIDTH
) (
    input  AMT_ENTRY [C_MT_ENTRY-1:0]                     table_i,
    input  ROB_AMT   [C_RT_NUM-1:0]                       rob_amt_i,
    output AMT_ENTRY [C_MT_ENTRY-1:0]                     table_o,
    output logic     [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0]  old_tag_o
);

    AMT_ENTRY [C_MT_ENTRY-1:0] work;

    // Walk the slots oldest first on a working copy, so a younger slot that
    // hits the same register sees (and frees) the older slot's tag and the
    // youngest write is what remains.
    always_comb begin
        work      = table_i;
        old_tag_o = '0;
        for (int r = 0; r < C_RT_NUM; r++) begin
            old_tag_o[r] = work[rob_amt_i[r].arch_reg].amt_tag;
            if (rob_amt_i[r].wr_en) begin
                work[rob_amt_i[r].arch_reg].amt_tag = rob_amt_i[r].phy_tag;
            end
        end
        table_o = work;
    end

endmodule

// File: rtl/arch_maptable.sv
// -----------------------------------------------------------------------------
// arch_maptable -- committed arch-reg -> phys-tag mapping (AMT).
//
// Written by the ROB at retirement. amt_o is the next-state table (stored
// table with this cycle's retirements applied) so a map-table rollback on the
// same edge picks up those retirements. Each superseded tag is sent to the
// free list one cycle after its retirement on amt_fl_o.
//
// Ports:
//   clk_i           clock, rising edge
//   rst_n_i         asynchronous active-low reset (table -> identity)
//   rollback_i      ROB flush pulse; does not change AMT contents
//   rob_amt_i       retire slots (wr_en, arch_reg, phy_tag), slot 0 oldest
//   amt_o           bypassed next-state table
//   amt_fl_o        registered freed tags, one per retire slot
//   retire_cnt_o    (ARCH_MT_STAT_EN only) total committed writes, wraps
//   rollback_cnt_o  (ARCH_MT_STAT_EN only) rollback cycles, wraps
//
// Optional feature macro: ARCH_MT_STAT_EN.
// -----------------------------------------------------------------------------
module arch_maptable
    import sys_defs::*;
#(
    parameter int C_RT_NUM         = `RT_NUM,
    parameter int C_MT_ENTRY       = `MT_ENTRY,
    parameter int C_TAG_IDX_WIDTH  = `TAG_IDX_WIDTH,
    parameter int C_ARCH_IDX_WIDTH = $clog2(C_MT_ENTRY)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      rollback_i,
    input  ROB_AMT   [C_RT_NUM-1:0]   rob_amt_i,
    output AMT_ENTRY [C_MT_ENTRY-1:0] amt_o,
    output AMT_FL    [C_RT_NUM-1:0]   amt_fl_o
`ifdef ARCH_MT_STAT_EN
    ,
    output logic [31:0]               retire_cnt_o,
    output logic [15:0]               rollback_cnt_o
`endif
);

    AMT_ENTRY [C_MT_ENTRY-1:0]                    table_q;
    AMT_ENTRY [C_MT_ENTRY-1:0]                    table_d;
    AMT_FL    [C_RT_NUM-1:0]                      fl_q;
    AMT_FL    [C_RT_NUM-1:0]                      fl_d;
    logic     [C_RT_NUM-1:0][C_TAG_IDX_WIDTH-1:0] old_tag;

    amt_retire_merge #(
        .C_RT_NUM        (C_RT_NUM),
        .C_MT_ENTRY      (C_MT_ENTRY),
        .C_TAG_IDX_WIDTH (C_TAG_IDX_WIDTH)
    ) u_merge (
        .table_i   (table_q),
        .rob_amt_i (rob_amt_i),
        .table_o   (table_d),
        .old_tag_o (old_tag)
    );

    // Slots without wr_en report valid=0 and a zero tag.
    always_comb begin
        fl_d = '0;
        for (int r = 0; r < C_RT_NUM; r++) begin
            fl_d[r].valid = rob_amt_i[r].wr_en;
            fl_d[r].tag   = rob_amt_i[r].wr_en ? old_tag[r] : '0;
        end
    end

    // rollback_i deliberately has no effect here: the AMT is the committed
    // state that the speculative table restores from.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < C_MT_ENTRY; i++) begin
                table_q[i].amt_tag <= C_TAG_IDX_WIDTH'(i);
            end
            fl_q <= '0;
        end else begin
            table_q <= table_d;
            fl_q    <= fl_d;
        end
    end

    assign amt_o    = table_d;
    assign amt_fl_o = fl_q;

`ifdef ARCH_MT_STAT_EN
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;
    logic [15:0] rollback_cnt_q;
    logic [15:0] rollback_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        for (int r = 0; r < C_RT_NUM; r++) begin
            if (rob_amt_i[r].wr_en) begin
                retire_cnt_d = retire_cnt_d + 32'd1;
            end
        end
        rollback_cnt_d = rollback_cnt_q + {15'd0, rollback_i};
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retire_cnt_q   <= '0;
            rollback_cnt_q <= '0;
        end else begin
            retire_cnt_q   <= retire_cnt_d;
            rollback_cnt_q <= rollback_cnt_d;
        end
    end

    assign retire_cnt_o   = retire_cnt_q;
    assign rollback_cnt_o = rollback_cnt_q;
`endif

endmodule

// File: tb/tb_arch_maptable.sv
module tb_arch_maptable;
  import sys_defs::*;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  logic rollback;
  ROB_AMT   [RT_NUM-1:0]   rob_amt;
  AMT_ENTRY [MT_ENTRY-1:0] amt;
  AMT_FL    [RT_NUM-1:0]   amt_fl;
`ifdef ARCH_MT_STAT_EN
  logic [31:0] retire_cnt;
  logic [15:0] rollback_cnt;
`endif

  always #5 clk = ~clk;

  arch_maptable dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .rollback_i (rollback),
    .rob_amt_i  (rob_amt),
    .amt_o      (amt),
    .amt_fl_o   (amt_fl)
`ifdef ARCH_MT_STAT_EN
    ,
    .retire_cnt_o   (retire_cnt),
    .rollback_cnt_o (rollback_cnt)
`endif
  );

  // ---------------------------------------------------------------- model
  // model_tbl: committed mapping; exp_amt: what amt_o must show this cycle;
  // exp_fl_*: what amt_fl_o must show this cycle; pend_fl_*: next cycle.
  int   model_tbl[MT_ENTRY];
  int   exp_amt[MT_ENTRY];
  logic exp_fl_v[RT_NUM];
  int   exp_fl_t[RT_NUM];
  logic pend_fl_v[RT_NUM];
  int   pend_fl_t[RT_NUM];
  longint exp_ret_cnt;
  longint exp_rb_cnt;
  int   pend_ret;
  int   pend_rb;

  int checks = 0;
  int passed = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic model_identity();
    for (int i = 0; i < MT_ENTRY; i++) begin
      model_tbl[i] = i;
      exp_amt[i]   = i;
    end
    for (int r = 0; r < RT_NUM; r++) begin
      exp_fl_v[r] = 1'b0; exp_fl_t[r] = 0;
      pend_fl_v[r] = 1'b0; pend_fl_t[r] = 0;
    end
    exp_ret_cnt = 0; exp_rb_cnt = 0; pend_ret = 0; pend_rb = 0;
  endtask

  // ---------------------------------------------------------------- driver
  // One cycle: commit the model on the edge, apply new inputs, then return at
  // the following negedge so the caller can make literal checks.
  task automatic drive(input logic e0, input int a0, input int t0,
                       input logic e1, input int a1, input int t1,
                       input logic rb);
    int en[RT_NUM];
    int ar[RT_NUM];
    int tg[RT_NUM];
    @(posedge clk);
    model_tbl = exp_amt;
    for (int r = 0; r < RT_NUM; r++) begin
      exp_fl_v[r] = pend_fl_v[r];
      exp_fl_t[r] = pend_fl_t[r];
    end
    exp_ret_cnt = (exp_ret_cnt + pend_ret) % (64'd1 << 32);
    exp_rb_cnt  = (exp_rb_cnt + pend_rb) % (64'd1 << 16);
    #1;
    en[0] = int'(e0); ar[0] = a0; tg[0] = t0;
    en[1] = int'(e1); ar[1] = a1; tg[1] = t1;
    rollback = rb;
    pend_ret = 0;
    pend_rb  = int'(rb);
    exp_amt  = model_tbl;
    for (int r = 0; r < RT_NUM; r++) begin
      rob_amt[r].wr_en    = en[r][0];
      rob_amt[r].arch_reg = ar[r][ARCH_IDX_WIDTH-1:0];
      rob_amt[r].phy_tag  = tg[r][TAG_IDX_WIDTH-1:0];
      // Retirements apply oldest first; each one frees whatever the
      // register maps to at that moment.
      pend_fl_v[r] = en[r] != 0;
      pend_fl_t[r] = 0;
      if (en[r] != 0) begin
        pend_fl_t[r]   = exp_amt[ar[r]];
        exp_amt[ar[r]] = tg[r];
        pend_ret++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; returns at the negedge while held.
  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rollback = 1'b0;
    rob_amt = '0;
    model_identity();
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (chk_en) begin
      int bad_idx;
      bad_idx = -1;
      for (int i = 0; i < MT_ENTRY; i++) begin
        if (bad_idx < 0 && int'(amt[i].amt_tag) != exp_amt[i]) bad_idx = i;
      end
      if (bad_idx < 0) check("amt_o table", 0, 0 + bad_idx + 1);
      else check($sformatf("amt_o[%0d]", bad_idx), amt[bad_idx].amt_tag, exp_amt[bad_idx]);
      for (int r = 0; r < RT_NUM; r++) begin
        check($sformatf("amt_fl_o[%0d].valid", r), amt_fl[r].valid, exp_fl_v[r]);
        check($sformatf("amt_fl_o[%0d].tag", r), amt_fl[r].tag, exp_fl_t[r]);
      end
`ifdef ARCH_MT_STAT_EN
      check("retire_cnt_o", retire_cnt, exp_ret_cnt);
      check("rollback_cnt_o", rollback_cnt, exp_rb_cnt);
`endif
    end
  end

  // ---------------------------------------------------------------- scenario
  initial begin
    rst_n = 1'b0;
    rollback = 1'b0;
    rob_amt = '0;
    model_identity();
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    // reset state, literal
    check("reset amt_o[0]", amt[0].amt_tag, 0);
    check("reset amt_o[17]", amt[17].amt_tag, 17);
    check("reset amt_o[31]", amt[31].amt_tag, 31);
    check("reset fl0 valid", amt_fl[0].valid, 0);
    check("reset fl1 valid", amt_fl[1].valid, 0);
    release_reset();

    // single retire with bypass
    drive(1'b1, 3, 33, 1'b0, 0, 0, 1'b0);
    check("bypass amt_o[3]", amt[3].amt_tag, 33);
    idle();
    check("stored amt_o[3]", amt[3].amt_tag, 33);
    check("free x3 valid", amt_fl[0].valid, 1);
    check("free x3 tag", amt_fl[0].tag, 3);
    check("free x3 slot1 valid", amt_fl[1].valid, 0);

    // two slots hit the same register
    drive(1'b1, 5, 40, 1'b1, 5, 41, 1'b0);
    check("same-reg amt_o[5]", amt[5].amt_tag, 41);
    idle();
    check("same-reg fl0 valid", amt_fl[0].valid, 1);
    check("same-reg fl0 tag", amt_fl[0].tag, 5);
    check("same-reg fl1 valid", amt_fl[1].valid, 1);
    check("same-reg fl1 tag", amt_fl[1].tag, 40);

    // retirements in a rollback cycle
    drive(1'b1, 1, 50, 1'b1, 2, 51, 1'b1);
    check("rb amt_o[1]", amt[1].amt_tag, 50);
    check("rb amt_o[2]", amt[2].amt_tag, 51);
    idle();
    check("post-rb amt_o[1]", amt[1].amt_tag, 50);
    check("post-rb amt_o[2]", amt[2].amt_tag, 51);
    check("rb fl0 tag", amt_fl[0].tag, 1);
    check("rb fl1 tag", amt_fl[1].tag, 2);

    // slot 1 alone
    idle();
    drive(1'b0, 0, 0, 1'b1, 7, 60, 1'b0);
    idle();
    check("slot1-only fl0 valid", amt_fl[0].valid, 0);
    check("slot1-only fl1 valid", amt_fl[1].valid, 1);
    check("slot1-only fl1 tag", amt_fl[1].tag, 7);

    // a few more directed vectors, including slot 1 freeing slot 0's write
    // to a different register and back-to-back reuse
    drive(1'b1, 7, 61, 1'b1, 3, 62, 1'b0);
    drive(1'b1, 3, 63, 1'b1, 7, 20, 1'b0);
    drive(1'b1, 31, 9, 1'b0, 0, 0, 1'b1);
    idle();
    check("vec amt_o[3]", amt[3].amt_tag, 63);
    check("vec amt_o[7]", amt[7].amt_tag, 20);
    check("vec amt_o[31]", amt[31].amt_tag, 9);

    // reset while a freed tag is pending
    drive(1'b1, 9, 12, 1'b0, 0, 0, 1'b0);
    pulse_reset();
    check("mid-reset fl0 valid", amt_fl[0].valid, 0);
    check("mid-reset amt_o[9]", amt[9].amt_tag, 9);
    check("mid-reset amt_o[3]", amt[3].amt_tag, 3);
    release_reset();

`ifdef ARCH_MT_STAT_EN
    drive(1'b1, 4, 40, 1'b1, 6, 41, 1'b0);
    drive(1'b1, 8, 42, 1'b1, 10, 43, 1'b1);
    drive(1'b1, 11, 44, 1'b1, 12, 45, 1'b0);
    idle();
    check("stat retire_cnt", retire_cnt, 6);
    check("stat rollback_cnt", rollback_cnt, 1);
`endif

    idle();
    idle();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
